// File: rtl/mul_share_arb.sv
// Two-requester round-robin front end for one shared 4x4 combinational multiplier.
// Operands are registered onto the multiplier, allowed LAT cycles to settle, then returned as a 1-cycle pulse.
module mul_share_arb #(
  parameter int LAT = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req0_valid,
  input  logic [3:0] req0_a,
  input  logic [3:0] req0_b,
  output logic       req0_ready,
  output logic       rsp0_valid,
  output logic [7:0] rsp0_p,
  input  logic       req1_valid,
  input  logic [3:0] req1_a,
  input  logic [3:0] req1_b,
  output logic       req1_ready,
  output logic       rsp1_valid,
  output logic [7:0] rsp1_p,
  output logic [3:0] mul_a,
  output logic [3:0] mul_b,
  input  logic [7:0] mul_p,
  output logic       busy
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  logic [1:0]      state;
  logic [2:0]      cnt;
  logic            last_grant, owner, win, capture;
  logic [1:0]      vld, rdy;
  logic [1:0][3:0] a_in, b_in;
  logic            rsp_v [2];
  logic [7:0]      rsp_p [2];

  assign vld  = {req1_valid, req0_valid};
  assign a_in = {req1_a, req0_a};
  assign b_in = {req1_b, req0_b};

  // On a tie the requester that did not win last time goes first.
  assign win     = (vld == 2'b11) ? ~last_grant : vld[1];
  assign capture = (state == CALC) && (cnt == 3'd1);
  assign busy    = (state == CALC) || (state == RESP);

  for (genvar i = 0; i < 2; i++) begin : g_req
    assign rdy[i] = rst_n && (state == IDLE) && vld[i] && (win == 1'(i));

    // Only the owner's response slot is touched; the other keeps its last product.
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        rsp_v[i] <= 1'b0;
        rsp_p[i] <= 8'd0;
      end else begin
        rsp_v[i] <= capture && (owner == 1'(i));
        if (capture && (owner == 1'(i))) rsp_p[i] <= mul_p;
      end
    end
  end

  assign req0_ready = rdy[0];
  assign req1_ready = rdy[1];
  assign rsp0_valid = rsp_v[0];
  assign rsp1_valid = rsp_v[1];
  assign rsp0_p     = rsp_p[0];
  assign rsp1_p     = rsp_p[1];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      owner      <= 1'b0;
      cnt        <= 3'd0;
      mul_a      <= 4'd0;
      mul_b      <= 4'd0;
    end else begin
      case (state)
        IDLE: if (|rdy) begin
          mul_a      <= a_in[win];
          mul_b      <= b_in[win];
          owner      <= win;
          last_grant <= win;
          cnt        <= 3'(LAT);
          state      <= CALC;
        end
        CALC: begin
          cnt <= cnt - 3'd1;
          if (cnt == 3'd1) state <= RESP;
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule
